// File: rtl/ram_sync_pkg.sv
// Shared types and helpers for the parametrised synchronous RAM.
// Holds the clear-sequencer state type, the parity function and the depth helper.
package ram_sync_pkg;

    // The clear sequencer needs only two states, so the state fits in one bit.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Parity helper operand width. Callers zero-extend to this width.
    // Zero-extension does not change the XOR, so this only requires DW <= PAR_MAX_W.
    localparam int unsigned PAR_MAX_W = 256;

    // Even parity bit: the XOR of all data bits.
    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

    // Number of words for a given address width.
    function automatic int unsigned calc_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear-sweep sequencer for ram_sync_param.
// Owns the IDLE/CLEAR state, the sweep pointer and busy. While sweeping, it drives
// one clear write per cycle. The sweep runs from address 0 up to and including the
// all-ones address.
module ram_clr_seq
    import ram_sync_pkg::*;
#(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    state_t        r_state;
    logic [AW-1:0] r_ptr;

    // State and pointer update. Reset always (re)starts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                ST_CLEAR: begin
                    // clr is ignored here. The sweep ends after the last word is written.
                    if (&r_ptr) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + AW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    // busy is decoded straight from the state register, so it has no combinational input path.
    always_comb begin
        busy     = (r_state == ST_CLEAR);
        clr_we   = busy;
        clr_addr = r_ptr;
    end

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with write-through and a sequenced clear.
// It has an active-low chip select and read/write-not control.
// Optional macro RAM_SYNC_PARITY_EN stores an even-parity bit per word.
// With that macro defined, par_err reports mismatches on reads.
module ram_sync_param
    import ram_sync_pkg::*;
#(
    parameter int unsigned   DW      = 4,
    parameter int unsigned   AW      = 4,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          csn,
    input  logic          rwn,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    input  logic          clr,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic          busy,
    output logic          par_err
);

    localparam int unsigned DEPTH = calc_depth(AW);
`ifdef RAM_SYNC_PARITY_EN
    localparam int unsigned MW = DW + 1;
`else
    localparam int unsigned MW = DW;
`endif

    logic [MW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_data_out;
    logic          r_rd_valid;
    logic          r_par_err;

    logic          w_busy;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_acc;
    logic          w_user_we;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [MW-1:0] w_wword;
    logic [MW-1:0] w_rword;
    logic [DW-1:0] w_rdata;
    logic          w_rpar_bad;

    ram_clr_seq #(
        .AW(AW)
    ) u_clr_seq (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .busy    (w_busy),
        .clr_we  (w_clr_we),
        .clr_addr(w_clr_addr)
    );

    // A user access is accepted only when no sweep is running, no sweep is starting, and rst is low.
    assign w_acc     = ~csn & ~w_busy & ~clr & ~rst;
    assign w_user_we = w_acc & ~rwn;

    // Clear and user writes never overlap (w_acc needs !busy), so a simple priority mux is enough.
    assign w_we    = w_clr_we | w_user_we;
    assign w_waddr = w_clr_we ? w_clr_addr : addr;
    assign w_wdata = w_clr_we ? CLR_VAL : data_in;
    assign w_rword = r_mem[addr];
    assign w_rdata = w_rword[DW-1:0];

`ifdef RAM_SYNC_PARITY_EN
    assign w_wword    = {calc_parity(PAR_MAX_W'(w_wdata)), w_wdata};
    assign w_rpar_bad = w_rword[DW] ^ calc_parity(PAR_MAX_W'(w_rdata));
`else
    assign w_wword    = w_wdata;
    assign w_rpar_bad = 1'b0;
`endif

    // Array write port. It is shared by the clear sweep and user writes. It is never reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wword;
        end
    end

    // Registered outputs: read data or write-through data, the valid strobe and the parity flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            r_rd_valid <= w_acc;
            r_par_err  <= w_acc & rwn & w_rpar_bad;
            if (w_acc) begin
                r_data_out <= rwn ? w_rdata : data_in;
            end
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign busy     = w_busy;
    assign par_err  = r_par_err;

endmodule

// File: tb/tb_ram_sync_param.sv
// Self-checking bench for ram_sync_param (DW=4, AW=4).
// A word-level model predicts the outputs after every clock edge. Directed
// scenarios then pin those predictions with literal expectations.
module tb_ram_sync_param;

    localparam int unsigned DW    = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          csn = 1'b1;
    logic          rwn = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_in = '0;
    logic          clr = 1'b0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          busy;
    logic          par_err;

    int n_cmp = 0;
    int n_err = 0;

    ram_sync_param #(
        .DW(DW),
        .AW(AW),
        .CLR_VAL(4'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .csn     (csn),
        .rwn     (rwn),
        .addr    (addr),
        .data_in (data_in),
        .clr     (clr),
        .data_out(data_out),
        .rd_valid(rd_valid),
        .busy    (busy),
        .par_err (par_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: word contents, sweep cycles left, expected outputs.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_bad [DEPTH];
    int            m_left = 0;
    logic [DW-1:0] e_dout = '0;
    bit            e_rv = 1'b0;
    bit            e_pe = 1'b0;
    bit            chk_en = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                e_dout = '0;
                e_rv   = 1'b0;
                e_pe   = 1'b0;
                m_left = DEPTH;
                chk_en = 1'b1;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                e_rv   = 1'b0;
                e_pe   = 1'b0;
                if (m_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        m_mem[i] = '0;
                        m_bad[i] = 1'b0;
                    end
                end
            end else if (clr) begin
                m_left = DEPTH;
                e_rv   = 1'b0;
                e_pe   = 1'b0;
            end else if (!csn) begin
                e_rv = 1'b1;
                if (!rwn) begin
                    m_mem[addr] = data_in;
                    m_bad[addr] = 1'b0;
                    e_dout      = data_in;
                    e_pe        = 1'b0;
                end else begin
                    e_dout = m_mem[addr];
                    e_pe   = m_bad[addr];
                end
            end else begin
                e_rv = 1'b0;
                e_pe = 1'b0;
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_cmp++;
                if (data_out !== e_dout || rd_valid !== e_rv || busy !== (m_left > 0) ||
                    par_err !== e_pe) begin
                    n_err++;
                    $display("FAIL model t=%0t got dout=%h rv=%b busy=%b pe=%b want dout=%h rv=%b busy=%b pe=%b",
                             $time, data_out, rd_valid, busy, par_err, e_dout, e_rv,
                             m_left > 0, e_pe);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        csn = 1'b1;
        clr = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        csn = 1'b0; rwn = 1'b0; addr = a; data_in = d;
        step();
        csn = 1'b1;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        csn = 1'b0; rwn = 1'b1; addr = a;
        step();
        csn = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy === 1'b1; i++) idle_cyc();
        check("wait_idle_bound", {31'd0, busy}, 32'd0);
    endtask

    // Counts busy cycles sampled at negedges after the current point, with a bound.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cnt++;
        end
    endtask

    int cnt;

    initial begin
        // Reset sweep: hold rst for two edges, then busy must stay high for exactly 16 cycles.
        rst = 1'b1;
        step();
        check("reset_dout", {28'd0, data_out}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd1);
        step();
        rst = 1'b0;
        count_busy(cnt);
        check("reset_sweep_len", cnt, 32'd16);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            rd(i[AW-1:0]);
            check("sweep_read_zero", {27'd0, rd_valid, data_out}, 32'h10);
        end

        // Write-through, read-back, then a deselected cycle.
        wr(4'h3, 4'hA);
        check("wt_data", {27'd0, rd_valid, data_out}, 32'h1A);
        rd(4'h3);
        check("rd_data", {27'd0, rd_valid, data_out}, 32'h1A);
        idle_cyc();
        check("csn_hold", {27'd0, rd_valid, data_out}, 32'h0A);

        // Write at sweep cycle 3 must be dropped.
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd1);
        idle_cyc();
        idle_cyc();
        wr(4'h5, 4'hF);
        check("busy_drop", {27'd0, rd_valid, data_out}, 32'h0A);
        wait_idle();
        rd(4'h5);
        check("busy_drop_rd", {27'd0, rd_valid, data_out}, 32'h10);

        // clr wins over a same-cycle write.
        for (int i = 0; i < DEPTH; i++) wr(i[AW-1:0], i[DW-1:0]);
        rd(4'h9);
        check("fill_rd", {28'd0, data_out}, 32'h9);
        clr = 1'b1; csn = 1'b0; rwn = 1'b0; addr = 4'h7; data_in = 4'h5;
        step();
        clr = 1'b0; csn = 1'b1;
        check("clr_vs_acc", {30'd0, busy, rd_valid}, 32'h2);
        wait_idle();
        for (int i = 0; i < DEPTH; i++) begin
            rd(i[AW-1:0]);
            check("clr_read_zero", {27'd0, rd_valid, data_out}, 32'h10);
        end

        // Reset at sweep cycle 8 restarts a full 16-cycle sweep.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 7; i++) idle_cyc();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(cnt);
        check("mid_reset_len", cnt, 32'd16);
        #1;

`ifdef RAM_SYNC_PARITY_EN
        // Corrupt one stored bit and expect par_err on the read.
        wait_idle();
        wr(4'h2, 4'h6);
        dut.r_mem[2][0] = ~dut.r_mem[2][0];
        m_mem[2] = m_mem[2] ^ 4'h1;
        m_bad[2] = 1'b1;
        rd(4'h2);
        check("par_bad", {26'd0, par_err, rd_valid, data_out}, 32'h37);
        wr(4'h2, 4'h6);
        rd(4'h2);
        check("par_ok", {26'd0, par_err, rd_valid, data_out}, 32'h16);
`endif

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            clr     = ($urandom_range(0, 39) == 0);
            csn     = ($urandom_range(0, 3) == 0);
            rwn     = $urandom_range(0, 1) == 1;
            addr    = AW'($urandom_range(0, DEPTH - 1));
            data_in = DW'($urandom_range(0, 15));
            step();
        end
        idle_cyc();
        idle_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
